// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store path and the instruction-fetch checker.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        is_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Byte count of an access; the illegal encoding is rejected elsewhere.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

  // Sign- or zero-extend right-justified load data to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                              input logic is_signed);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {{24{is_signed & raw[7]}}, raw[7:0]};
      SIZE_HALF: r = {{16{is_signed & raw[15]}}, raw[15:0]};
      default:   r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the MEM stage and the access controller.
interface mem_access_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  // Requester side (pipeline MEM stage).
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

endinterface

// File: rtl/mem_align_check.sv
// Combinational alignment and range check for a sized byte-addressed access.
module mem_align_check
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  output logic        fault_o
);

  logic [32:0] end_addr;

  // 33-bit end address so accesses near 2^32 fault instead of wrapping.
  always_comb begin
    end_addr = {1'b0, addr_i} + {30'b0, size_bytes(size_i)};
    fault_o  = 1'b0;
    case (size_i)
      SIZE_BYTE: fault_o = 1'b0;
      SIZE_HALF: fault_o = addr_i[0];
      SIZE_WORD: fault_o = |addr_i[1:0];
      default:   fault_o = 1'b1;
    endcase
    if (end_addr > 33'(MEM_BYTES)) begin
      fault_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller: one request at a time, one RAM cycle, extended response.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_access_ctrl_if.slave  bus,
  output logic              ram_rw,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_din,
  output logic [1:0]        ram_size,
  input  logic [31:0]       ram_dout,
  output logic [FCNT_W-1:0] fault_count
);

  state_e            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              align_fault;

  mem_align_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_align (
    .size_i (bus.req_size),
    .addr_i (bus.req_addr),
    .fault_o(align_fault)
  );

  // State and request/response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      req_q.write     <= 1'b0;
      req_q.size      <= SIZE_WORD;
      req_q.is_signed <= 1'b0;
      req_q.addr      <= '0;
      req_q.wdata     <= '0;
      rdata_q         <= '0;
      fault_q         <= 1'b0;
      fcnt_q          <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state: accept/check in IDLE, capture load data in ACCESS, hold in RESP.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (align_fault) begin
            // req_q is left alone so the RAM address/data/size keep their last values.
            state_d = RESP;
            fault_d = 1'b1;
            rdata_d = '0;
            if (fcnt_q != {FCNT_W{1'b1}}) begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end else begin
            state_d         = ACCESS;
            fault_d         = 1'b0;
            req_d.write     = bus.req_write;
            req_d.size      = bus.req_size;
            req_d.is_signed = bus.req_signed;
            req_d.addr      = bus.req_addr;
            req_d.wdata     = bus.req_wdata;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = req_q.write ? 32'h0 : extend_load(ram_dout, req_q.size, req_q.is_signed);
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: write strobe is decoded from the state so reset kills it asynchronously.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_fault = fault_q;
    ram_rw        = (state_q == ACCESS) && req_q.write;
    ram_addr      = req_q.addr;
    ram_din       = req_q.wdata;
    ram_size      = req_q.size;
    fault_count   = fcnt_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-array RAM model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ram_rw;
  logic [31:0]       ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic [1:0]        ram_size;
  logic [7:0]        fault_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(
    .MEM_BYTES(256),
    .FCNT_W   (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .ram_rw     (ram_rw),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_size   (ram_size),
    .ram_dout   (ram_dout),
    .fault_count(fault_count)
  );

  // RAM model: combinational read, write on clock edge, plus a bench preload port.
  logic [7:0] mem [256];
  logic       pl_clr = 1'b0;
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h0;
  logic [7:0] pl_data = 8'h0;
  logic [7:0] ra;

  always_comb begin
    ra = ram_addr[7:0];
    case (ram_size)
      2'b00:   ram_dout = {24'h0, mem[ra]};
      2'b01:   ram_dout = {16'h0, mem[ra + 8'd1], mem[ra]};
      default: ram_dout = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
    endcase
  end

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h0;
    end else if (ram_rw) begin
      mem[ra] <= ram_din[7:0];
      if (ram_size != 2'b00) mem[ra + 8'd1] <= ram_din[15:8];
      if (ram_size == 2'b10) begin
        mem[ra + 8'd2] <= ram_din[23:16];
        mem[ra + 8'd3] <= ram_din[31:24];
      end
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  // Issue one request with rsp_ready high; report data, fault, latency and write cycles.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic flt,
                        output int lat, output int rw_cyc);
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    n_vec++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL req_ready_idle: got %b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat    = 1;
    rw_cyc = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 12) begin
      if (ram_rw === 1'b1) rw_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.rsp_rdata;
    flt   = bus.rsp_fault;
    if (bus.rsp_valid !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_timeout: got rsp_valid %b want 1 within %0d cycles", bus.rsp_valid, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] got [9];
    logic [31:0] exp [9];
    got = '{32'(bus.req_ready), 32'(bus.rsp_valid), bus.rsp_rdata, 32'(bus.rsp_fault),
            32'(ram_rw), ram_addr, ram_din, 32'(ram_size), 32'(fault_count)};
    exp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0};
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL reset_value[%0d]: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_word_load();
    logic [31:0] rd;
    logic        f;
    int          lat, rw;
    poke(8'h00, 8'h78);
    poke(8'h01, 8'h56);
    poke(8'h02, 8'h34);
    poke(8'h03, 8'h12);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, rd, f, lat, rw);
    n_vec += 4;
    if (rd !== 32'h12345678) begin n_err++; $display("FAIL word_load_data: got %h want 12345678", rd); end
    if (f !== 1'b0) begin n_err++; $display("FAIL word_load_fault: got %b want 0", f); end
    if (lat != 2) begin n_err++; $display("FAIL word_load_latency: got %0d want 2", lat); end
    if (rw != 0) begin n_err++; $display("FAIL word_load_rw: got %0d want 0", rw); end
  endtask

  task automatic test_extend();
    logic [1:0]  sz  [4] = '{SIZE_BYTE, SIZE_BYTE, SIZE_HALF, SIZE_HALF};
    logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [4] = '{32'h0, 32'h0, 32'h2, 32'h2};
    logic [31:0] exp [4] = '{32'hFFFFFFB5, 32'h000000B5, 32'hFFFFFFD3, 32'h0000FFD3};
    logic [31:0] rd;
    logic        f;
    int          lat, rw;
    poke(8'h00, 8'hB5);
    poke(8'h02, 8'hD3);
    poke(8'h03, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz[i], sg[i], ad[i], 32'h0, rd, f, lat, rw);
      n_vec += 2;
      if (rd !== exp[i]) begin n_err++; $display("FAIL extend_data[%0d]: got %h want %h", i, rd, exp[i]); end
      if (f !== 1'b0) begin n_err++; $display("FAIL extend_fault[%0d]: got %b want 0", i, f); end
    end
  endtask

  task automatic test_store();
    logic [31:0] rd;
    logic        f;
    int          lat, rw;
    do_req(1'b1, SIZE_WORD, 1'b0, 32'h8, 32'hE35D8AC5, rd, f, lat, rw);
    n_vec += 6;
    if (rd !== 32'h0) begin n_err++; $display("FAIL store_rdata: got %h want 0", rd); end
    if (f !== 1'b0) begin n_err++; $display("FAIL store_fault: got %b want 0", f); end
    if (rw != 1) begin n_err++; $display("FAIL store_rw_cycles: got %0d want 1", rw); end
    if (lat != 2) begin n_err++; $display("FAIL store_latency: got %0d want 2", lat); end
    if (ram_rw !== 1'b0) begin n_err++; $display("FAIL store_rw_idle: got %b want 0", ram_rw); end
    if (ram_din !== 32'hE35D8AC5) begin n_err++; $display("FAIL store_din_hold: got %h want e35d8ac5", ram_din); end
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, rd, f, lat, rw);
    n_vec++;
    if (rd !== 32'hE35D8AC5) begin n_err++; $display("FAIL store_readback: got %h want e35d8ac5", rd); end
    // Byte store must touch only one byte.
    do_req(1'b1, SIZE_BYTE, 1'b0, 32'h9, 32'h000000AA, rd, f, lat, rw);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, rd, f, lat, rw);
    n_vec++;
    if (rd !== 32'hE35DAAC5) begin n_err++; $display("FAIL byte_store_merge: got %h want e35daac5", rd); end
  endtask

  task automatic test_faults();
    logic [1:0]  sz [6] = '{SIZE_HALF, SIZE_WORD, 2'b11, SIZE_WORD, SIZE_BYTE, SIZE_HALF};
    logic [31:0] ad [6] = '{32'h3, 32'h6, 32'h0, 32'hFE, 32'h100, 32'hFFFFFFFE};
    logic [31:0] rd;
    logic        f;
    int          lat, rw;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b1, sz[i], 1'b0, ad[i], 32'hDEADBEEF, rd, f, lat, rw);
      n_vec += 5;
      if (f !== 1'b1) begin n_err++; $display("FAIL fault_flag[%0d]: got %b want 1", i, f); end
      if (rd !== 32'h0) begin n_err++; $display("FAIL fault_rdata[%0d]: got %h want 0", i, rd); end
      if (lat != 1) begin n_err++; $display("FAIL fault_latency[%0d]: got %0d want 1", i, lat); end
      if (rw != 0) begin n_err++; $display("FAIL fault_rw[%0d]: got %0d want 0", i, rw); end
      if (ram_addr !== 32'h8) begin n_err++; $display("FAIL fault_addr_hold[%0d]: got %h want 8", i, ram_addr); end
      if (i == 3) begin
        n_vec++;
        if (fault_count !== 8'd4) begin n_err++; $display("FAIL fault_count_4: got %0d want 4", fault_count); end
      end
    end
    n_vec++;
    if (fault_count !== 8'd6) begin n_err++; $display("FAIL fault_count_6: got %0d want 6", fault_count); end
    // Last word and last byte are in range.
    do_req(1'b0, SIZE_WORD, 1'b0, 32'hFC, 32'h0, rd, f, lat, rw);
    n_vec++;
    if (f !== 1'b0) begin n_err++; $display("FAIL top_word_fault: got %b want 0", f); end
    do_req(1'b0, SIZE_BYTE, 1'b0, 32'hFF, 32'h0, rd, f, lat, rw);
    n_vec++;
    if (f !== 1'b0) begin n_err++; $display("FAIL top_byte_fault: got %b want 0", f); end
  endtask

  task automatic test_saturate();
    logic [31:0] rd;
    logic        f;
    int          lat, rw;
    for (int i = 0; i < 300; i++) begin
      do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, rd, f, lat, rw);
    end
    n_vec++;
    if (fault_count !== 8'd255) begin n_err++; $display("FAIL fault_saturate: got %0d want 255", fault_count); end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = SIZE_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h8;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    // A competing store is presented while the response is held; it must be ignored.
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_vec += 4;
      if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", c, bus.rsp_valid); end
      if (bus.rsp_rdata !== 32'hE35DAAC5) begin n_err++; $display("FAIL hold_rdata[%0d]: got %h want e35daac5", c, bus.rsp_rdata); end
      if (bus.rsp_fault !== 1'b0) begin n_err++; $display("FAIL hold_fault[%0d]: got %b want 0", c, bus.rsp_fault); end
      if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL hold_req_ready[%0d]: got %b want 0", c, bus.req_ready); end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec += 3;
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b want 0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", bus.req_ready); end
    if (mem[8'h20] !== 8'h00) begin n_err++; $display("FAIL ignored_store: got %h want 00", mem[8'h20]); end
  endtask

  task automatic test_reset_mid_access();
    logic seen_valid;
    bus.req_write  = 1'b1;
    bus.req_size   = SIZE_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h11223344;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_vec++;
    if (ram_rw !== 1'b1) begin n_err++; $display("FAIL mid_access_rw: got %b want 1", ram_rw); end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (ram_rw !== 1'b0) begin n_err++; $display("FAIL reset_rw_async: got %b want 0", ram_rw); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen_valid = 1'b1;
    end
    n_vec += 5;
    if (seen_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_rsp: got %b want 0", seen_valid); end
    if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    if (fault_count !== 8'd0) begin n_err++; $display("FAIL reset_fault_count: got %0d want 0", fault_count); end
    if (ram_size !== 2'b10) begin n_err++; $display("FAIL reset_ram_size: got %b want 10", ram_size); end
    if (mem[8'h10] !== 8'h00) begin n_err++; $display("FAIL reset_no_write: got %h want 00", mem[8'h10]); end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    pl_clr = 1'b1;
    @(posedge clk); #1;
    pl_clr = 1'b0;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_word_load();
    test_extend();
    test_store();
    test_faults();
    test_saturate();
    test_backpressure();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
